// File: rtl/sqrt_int_arbiter_pkg.sv
// Shared types and helpers for the sqrt_int round-robin arbiter.
package sqrt_arb_pkg;

  // Arbiter sequencing states: accept, kick the core, wait for it, hand back.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  // Requester ID width; a single requester still gets a 1-bit ID.
  function automatic int ID_W(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sqrt_int_arbiter_if.sv
// Link between the arbiter (master) and the shared sqrt_int core (slave).
interface sqrt_int_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] rad;
  logic             busy;
  logic             valid;
  logic [WIDTH-1:0] root;
  logic [WIDTH-1:0] rem;

  modport master (output start, output rad, input busy, input valid, input root, input rem);
  modport slave  (input start, input rad, output busy, output valid, output root, output rem);
endinterface

// File: rtl/sqrt_int_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]       req,
  input  logic [ID_W(N)-1:0] ptr,
  output logic [N-1:0]       gnt,
  output logic [ID_W(N)-1:0] gnt_id
);
  localparam int IW = ID_W(N);

  logic w_found;

  // Scan upward from ptr and stop at the first pending requester
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    w_found = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && req[(int'(ptr) + k) % N]) begin
        w_found                   = 1'b1;
        gnt[(int'(ptr) + k) % N]  = 1'b1;
        gnt_id                    = IW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/sqrt_int_arbiter.sv
// Shares one sqrt_int core among N requesters, one request in flight at a time,
// and returns ID-tagged results (or a timeout error) on a backpressured channel.
module sqrt_int_arbiter
  import sqrt_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_rad,
  output logic [N-1:0]         req_ready,
  sqrt_int_if.master           core,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [ID_W(N)-1:0]   resp_id,
  output logic [WIDTH-1:0]     resp_root,
  output logic [WIDTH-1:0]     resp_rem,
  output logic                 resp_err
);
  localparam int IW    = ID_W(N);
  localparam int CNT_W = $clog2(TIMEOUT) + 1;

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [IW-1:0]    r_rr_ptr;
  logic [IW-1:0]    r_id;
  logic [WIDTH-1:0] r_rad;
  logic [WIDTH-1:0] r_root;
  logic [WIDTH-1:0] r_rem;
  logic             r_err;
  logic [CNT_W-1:0] r_cnt;

  logic [N-1:0]     w_gnt;
  logic [IW-1:0]    w_gnt_id;
  logic [WIDTH-1:0] w_rad_arr [N];
  logic             w_timeout;

  // Unpack the flat radicand bus into one lane per requester
  for (genvar gi = 0; gi < N; gi++) begin : g_rad_lane
    assign w_rad_arr[gi] = req_rad[gi*WIDTH +: WIDTH];
  end

  rr_arbiter #(.N(N)) u_rr (
    .req    (req_valid),
    .ptr    (r_rr_ptr),
    .gnt    (w_gnt),
    .gnt_id (w_gnt_id)
  );

  // Last waiting cycle: the core has had TIMEOUT cycles in WAIT without answering
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; a stale core valid outside WAIT is deliberately ignored
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|req_valid) w_state_next = START;
      START:   w_state_next = WAIT;
      WAIT:    if (core.valid || w_timeout) w_state_next = RESP;
      RESP:    if (resp_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Request latch, timeout counter, response registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_rad    <= '0;
      r_root   <= '0;
      r_rem    <= '0;
      r_err    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_rad <= w_rad_arr[w_gnt_id];
            r_id  <= w_gnt_id;
          end
        end
        START: r_cnt <= '0;
        WAIT: begin
          if (core.valid) begin
            r_root <= core.root;
            r_rem  <= core.rem;
            r_err  <= 1'b0;
          end else if (w_timeout) begin
            r_root <= '0;
            r_rem  <= '0;
            r_err  <= 1'b1;
          end else if (r_cnt != {CNT_W{1'b1}}) begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) r_rr_ptr <= (r_id == IW'(N - 1)) ? '0 : r_id + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
  assign core.start = (r_state == START);
  assign core.rad   = r_rad;
  assign resp_valid = (r_state == RESP);
  assign resp_id    = r_id;
  assign resp_root  = r_root;
  assign resp_rem   = r_rem;
  assign resp_err   = r_err;

  // Simulation-only check: never start the core while it still reports busy
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(core.start && core.busy));
    end
  end

endmodule

// File: doc/sqrt_int_arbiter.md
# sqrt_int_arbiter

Round-robin scheduler that shares one `sqrt_int` core among `N` requesters. It accepts one radicand at a time over per-requester valid/ready handshakes and sequences the core's `start`/`valid` protocol. It returns `root`/`rem` tagged with the requester ID over a single backpressured response channel. It sits between the client blocks and the core, connected to the core through `sqrt_int_if`.

## Interface

Parameters:
- `WIDTH`, 8: radicand, root and remainder width; must match the core.
- `N`, 4: number of requesters, 2..16.
- `TIMEOUT`, 64: maximum cycles spent waiting for core `valid` before an error response.

Ports:
- `clk`, input, 1: clock. Everything is sampled on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `req_valid`, input, N: per-requester request valid.
- `req_rad`, input, N*WIDTH: radicands. Requester i uses bits [i*WIDTH +: WIDTH].
- `req_ready`, output, N: one-hot grant. Combinational, asserted only in IDLE.
- `sqrt_start`, output, 1: start pulse to the core.
- `sqrt_rad`, output, WIDTH: radicand to the core.
- `sqrt_busy`, input, 1: core busy. Monitored only.
- `sqrt_valid`, input, 1: core result valid.
- `sqrt_root`, input, WIDTH: core root.
- `sqrt_rem`, input, WIDTH: core remainder.
- `resp_valid`, output, 1: response valid.
- `resp_ready`, input, 1: response consumer ready.
- `resp_id`, output, $clog2(N): ID of the requester the response belongs to.
- `resp_root`, output, WIDTH: registered root.
- `resp_rem`, output, WIDTH: registered remainder.
- `resp_err`, output, 1: the response is a timeout. `resp_root` and `resp_rem` are 0 when set.

## Operation

The FSM has four states: IDLE, START, WAIT and RESP.

- **IDLE**
  - If any `req_valid` bit is set, grant g = the first set bit at or after `rr_ptr`, searching upward with wrap.
  - `req_ready[g]=1` in the same cycle; the transfer happens on that edge.
  - On transfer, latch `req_rad[g]` into `rad_q` and g into `id_q`, then go to START.
  - Ungranted requesters see `req_ready=0` and must hold their `req_valid`.
- **START**
  - `sqrt_start=1` for exactly one cycle, with `sqrt_rad=rad_q`.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - On `sqrt_valid=1`, capture `sqrt_root`/`sqrt_rem` into the response registers with `resp_err=0`, then go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT-1` without `valid`, load root=0, rem=0 and `resp_err=1`, then go to RESP.
- **RESP**
  - Hold `resp_valid=1` and keep all `resp_*` stable until `resp_ready=1`.
  - On the handshake, set `rr_ptr = (id_q+1) mod N` and go to IDLE.
- **Sequencing:** only one request is in flight at a time. The core is never started while the arbiter is in WAIT or RESP.
- **Ignored `sqrt_valid`:** the arbiter ignores `sqrt_valid` outside WAIT, including a stale `valid` in START.
- **`sqrt_busy`:** not used for sequencing. It is only checked by the assertion below.
- **Assertion:** in simulation only, `sqrt_start` must never be asserted while `sqrt_busy=1`.

## Timing

- **Reset values:** reset forces IDLE, `rr_ptr=0` and `rad_q=0`.
  - Outputs after reset: `req_ready=0` (given `req_valid=0`), `sqrt_start=0`, `sqrt_rad=0`, `resp_valid=0`, `resp_id=0`, `resp_root=0`, `resp_rem=0`, `resp_err=0`.
- **Reset mid-operation:** reset in any state takes effect at the next edge, and the in-flight request is dropped. The core is reset by the same `rst`.
- **Latency:** let grant be at cycle 0.
  - `sqrt_start` is high in cycle 1.
  - With core result `valid` in cycle 1+L, `resp_valid` is first high in cycle 2+L.
  - The minimum accept-to-accept interval is L+3 cycles, with `resp_ready` held at 1.
- **Same-cycle arrivals:** simultaneous requests are served in round-robin order starting from `rr_ptr`.
- **Fairness:** a requester holding `req_valid` waits at most N-1 other transactions.
- **Pointer wrap:** with `id_q=N-1`, `rr_ptr` becomes 0.
- **Grant-cycle changes:** a `req_valid` that rises in the grant cycle for a different index is not granted that cycle.
- **Timeout:** `resp_err` rises `TIMEOUT`+1 cycles after `sqrt_start`.
- **Widths:** all datapaths are `WIDTH` bits with no arithmetic on data. The timeout counter is $clog2(TIMEOUT)+1 bits and saturates.

## Structure

- **Package `sqrt_arb_pkg`:**
  - `arb_state_t` enum {IDLE, START, WAIT, RESP}.
  - `ID_W` localparam function.
- **Sub-module `rr_arbiter`:** parameterised by N.
  - Inputs: `req[N]` and `ptr`.
  - Outputs: one-hot `gnt` and encoded `gnt_id`.
  - Purely combinational and reusable.
- **Top level:** the FSM, registers, timeout counter and assertion.

## Test plan

- **Single request:** requester 2 sends rad=100 → grant on `req_ready[2]` only, one-cycle `sqrt_start` with `sqrt_rad=100`. Expected response: id=2, root=10, rem=0, err=0.
- **Simultaneous requests with `rr_ptr=0`:** all four `req_valid` with rad 0/1/255/50 → responses in id order 0,1,2,3 with (0,0), (1,0), (15,30) and (7,1).
  - A second full burst is served in order 0,1,2,3 again, since `rr_ptr` wraps from 3 to 0.
- **Backpressure:** `resp_ready=0` for 10 cycles after `resp_valid` → `resp_*` stay stable and `req_ready` stays 0 throughout. The next grant comes 1 cycle after the handshake.
- **Timeout:** a core model that never asserts `valid` → `resp_err=1` with root=0 and rem=0 at `TIMEOUT`+1 cycles after `start`. The next request then completes normally.
- **Reset in WAIT:** assert `rst` while in WAIT → all outputs at reset values next cycle and `rr_ptr=0`. A late `sqrt_valid` produces no response.
- **Starvation:** requester 0 holds `req_valid` continuously while requester 1 re-requests → grants alternate 0,1,0,1 and the no-start-while-busy assertion never fires.
